// File: rtl/io_input_conditioner.sv
// Synchronizes, normalizes and debounces 10 switches and 4 keys; generates key press pulses and sticky events.
// Latency: a held raw change reaches io_input_bus DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; all outputs are registered and update every cycle with no flow control.
module io_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 20,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  switches_in,
   input  logic [3:0]  keys_in,
   input  logic [3:0]  clear_events,
   output logic [13:0] io_input_bus,
   output logic [3:0]  key_pressed,
   output logic [3:0]  key_event
);

   localparam int NBITS = 14;

   // Raw key level when nothing is pressed; doubles as the XOR mask that
   // turns synchronized key levels into 1 = pressed.
   localparam logic [3:0] KEY_RELEASED = (KEY_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   // Counter value on which a still-differing bit is finally accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [9:0]       sw_meta;
   logic [9:0]       sw_sync;
   logic [3:0]       key_meta;
   logic [3:0]       key_sync;
   logic [13:0]      norm;
   logic [13:0]      stable;
   logic [13:0]      stable_next;
   logic [CNT_W-1:0] cnt      [NBITS];
   logic [CNT_W-1:0] cnt_next [NBITS];
   logic [3:0]       key_rise;

   // Two-flop synchronizers; keys reset to their released level so no
   // spurious difference is seen right after reset release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= KEY_RELEASED;
         key_sync <= KEY_RELEASED;
      end else begin
         sw_meta  <= switches_in;
         sw_sync  <= sw_meta;
         key_meta <= keys_in;
         key_sync <= key_meta;
      end
   end

   // Normalized levels: keys become 1 = pressed, switches pass unchanged.
   always_comb begin
      norm = {key_sync ^ KEY_RELEASED, sw_sync};
   end

   // Per-bit debounce: count consecutive differing cycles, accept the new
   // level once it has differed for DEBOUNCE_CYCLES cycles in a row.
   always_comb begin
      stable_next = stable;
      for (int i = 0; i < NBITS; i++) begin
         cnt_next[i] = '0;
         if (norm[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST) begin
               stable_next[i] = norm[i];
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Debounced state and counters; reset abandons any count in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         for (int i = 0; i < NBITS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable <= stable_next;
         for (int i = 0; i < NBITS; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   // A press is a 0->1 step of a debounced key bit on this edge.
   always_comb begin
      key_rise = stable_next[13:10] & ~stable[13:10];
   end

   // One-cycle press pulses and sticky press flags; a press on the same
   // edge as a clear keeps the flag set.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_pressed <= '0;
         key_event   <= '0;
      end else begin
         key_pressed <= key_rise;
         key_event   <= (key_event & ~clear_events) | key_rise;
      end
   end

   assign io_input_bus = stable;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboarded bench for io_input_conditioner with DEBOUNCE_CYCLES=4.
// Directed scenarios followed by randomized switch/key/clear/reset activity.
module tb_io_input_conditioner;

   localparam int DEB = 4;
   localparam int KAL = 1;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  switches_in = 10'h0;
   logic [3:0]  keys_in = 4'hF;
   logic [3:0]  clear_events = 4'h0;
   logic [13:0] io_input_bus;
   logic [3:0]  key_pressed;
   logic [3:0]  key_event;

   io_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(20),
      .KEY_ACTIVE_LOW(KAL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .switches_in(switches_in),
      .keys_in(keys_in),
      .clear_events(clear_events),
      .io_input_bus(io_input_bus),
      .key_pressed(key_pressed),
      .key_event(key_event)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [13:0] bus;
      logic [3:0]  pressed;
      logic [3:0]  evt;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int edge_no  = 0;
   int pulses[4];
   int last_pulse[4];

   // Reference model state: raw-pin delay through the synchronizer, the
   // last DEB normalized samples seen by the debouncer, and the outputs.
   logic [9:0]  m_sw1 = 10'h0, m_sw2 = 10'h0;
   logic [3:0]  m_k1 = 4'hF, m_k2 = 4'hF;
   logic [13:0] m_stable = 14'h0;
   logic [13:0] m_win[$];
   logic [3:0]  m_pressed = 4'h0;
   logic [3:0]  m_event = 4'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
   endtask

   // A bit follows its input once the last DEB samples all disagree with it.
   task automatic model_edge(input logic [9:0] sw, input logic [3:0] k,
                             input logic [3:0] clr, input bit in_reset);
      logic [13:0] smp;
      logic [13:0] nxt;
      bit          all_diff;
      if (in_reset) begin
         m_sw1 = 10'h0; m_sw2 = 10'h0;
         m_k1 = 4'hF;   m_k2 = 4'hF;
         m_stable = 14'h0;
         m_win.delete();
         m_pressed = 4'h0;
         m_event = 4'h0;
      end else begin
         smp = {(KAL != 0) ? ~m_k2 : m_k2, m_sw2};
         m_win.push_back(smp);
         if (m_win.size() > DEB) void'(m_win.pop_front());
         nxt = m_stable;
         if (m_win.size() == DEB) begin
            for (int b = 0; b < 14; b++) begin
               all_diff = 1'b1;
               foreach (m_win[j]) if (m_win[j][b] == m_stable[b]) all_diff = 1'b0;
               if (all_diff) nxt[b] = ~m_stable[b];
            end
         end
         m_pressed = nxt[13:10] & ~m_stable[13:10];
         m_event = (m_event & ~clr) | m_pressed;
         m_stable = nxt;
         m_sw2 = m_sw1; m_sw1 = sw;
         m_k2 = m_k1;   m_k1 = k;
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, queue the expectation,
   // then record press pulses seen after the edge.
   task automatic step(input logic [9:0] sw, input logic [3:0] k,
                       input logic [3:0] clr, input bit in_reset);
      exp_t e;
      #2;
      switches_in  = sw;
      keys_in      = k;
      clear_events = clr;
      reset        = in_reset ? 1'b0 : 1'b1;
      @(posedge clock);
      model_edge(sw, k, clr, in_reset);
      e.bus = m_stable; e.pressed = m_pressed; e.evt = m_event;
      exp_q.push_back(e);
      edge_no++;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (key_pressed[i] === 1'b1) begin
            pulses[i]++;
            last_pulse[i] = edge_no;
         end
      end
   endtask

   task automatic clear_stats();
      edge_no = 0;
      for (int i = 0; i < 4; i++) begin
         pulses[i] = 0;
         last_pulse[i] = -1;
      end
   endtask

   // Monitor: every cycle the DUT presents a new output word; compare it
   // against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_bus", 32'(io_input_bus), 32'(e.bus));
            check("sb_key_pressed", 32'(key_pressed), 32'(e.pressed));
            check("sb_key_event", 32'(key_event), 32'(e.evt));
         end
      end
   end

   initial begin
      logic [9:0] sw_r;
      logic [3:0] k_r;
      logic [3:0] clr_r;
      bit         rst_r;

      clear_stats();
      // Reset state and quiet release
      repeat (3) step(10'h0, 4'hF, 4'h0, 1'b1);
      check("reset_bus", 32'(io_input_bus), 32'h0);
      check("reset_event", 32'(key_event), 32'h0);
      clear_stats();
      repeat (20) step(10'h0, 4'hF, 4'h0, 1'b0);
      check("idle_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'h0);
      check("idle_event", 32'(key_event), 32'h0);
      check("idle_bus", 32'(io_input_bus), 32'h0);

      // Switch change first sampled at edge 1 appears after edge 6
      clear_stats();
      repeat (5) step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("sw_edge5", 32'(io_input_bus[9:0]), 32'h0);
      step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("sw_edge6", 32'(io_input_bus[9:0]), 32'h2A5);
      repeat (3) step(10'h2A5, 4'hF, 4'h0, 1'b0);

      // Three-cycle key glitch is rejected
      clear_stats();
      repeat (3) step(10'h2A5, 4'hB, 4'h0, 1'b0);
      repeat (8) step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("glitch_bus12", 32'(io_input_bus[12]), 32'h0);
      check("glitch_pulses", 32'(pulses[2]), 32'h0);

      // Held key press: accepted at edge 6 with a single pulse
      clear_stats();
      repeat (5) step(10'h2A5, 4'hB, 4'h0, 1'b0);
      check("key_edge5", 32'(io_input_bus[12]), 32'h0);
      step(10'h2A5, 4'hB, 4'h0, 1'b0);
      check("key_edge6", 32'(io_input_bus[12]), 32'h1);
      check("key_pulse_on", 32'(key_pressed[2]), 32'h1);
      step(10'h2A5, 4'hB, 4'h0, 1'b0);
      check("key_pulse_off", 32'(key_pressed[2]), 32'h0);
      repeat (8) step(10'h2A5, 4'hB, 4'h0, 1'b0);
      check("key_pulse_count", 32'(pulses[2]), 32'h1);
      check("key_event_set", 32'(key_event[2]), 32'h1);

      // Clear, clear while already clear, then clear coinciding with a press
      step(10'h2A5, 4'hB, 4'h4, 1'b0);
      check("event_cleared", 32'(key_event[2]), 32'h0);
      step(10'h2A5, 4'hB, 4'h4, 1'b0);
      check("event_clear_idle", 32'(key_event[2]), 32'h0);
      repeat (8) step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("key_released", 32'(io_input_bus[12]), 32'h0);
      clear_stats();
      repeat (5) step(10'h2A5, 4'hB, 4'h0, 1'b0);
      step(10'h2A5, 4'hB, 4'h4, 1'b0);
      check("set_wins_edge", 32'(last_pulse[2]), 32'd6);
      check("set_wins_event", 32'(key_event[2]), 32'h1);
      repeat (8) step(10'h2A5, 4'hF, 4'h0, 1'b0);

      // Bounce on key 0: L,H,L,H,L then held; last change sampled at edge 5
      clear_stats();
      step(10'h2A5, 4'hE, 4'h0, 1'b0);
      step(10'h2A5, 4'hF, 4'h0, 1'b0);
      step(10'h2A5, 4'hE, 4'h0, 1'b0);
      step(10'h2A5, 4'hF, 4'h0, 1'b0);
      repeat (11) step(10'h2A5, 4'hE, 4'h0, 1'b0);
      check("bounce_count", 32'(pulses[0]), 32'h1);
      check("bounce_edge", 32'(last_pulse[0]), 32'd10);
      repeat (8) step(10'h2A5, 4'hF, 4'h0, 1'b0);

      // Reset in the middle of a switch debounce count
      repeat (8) step(10'h0, 4'hF, 4'h0, 1'b0);
      check("sw_back_to_0", 32'(io_input_bus), 32'h0);
      repeat (4) step(10'h2A5, 4'hF, 4'h0, 1'b0);
      step(10'h2A5, 4'hF, 4'h0, 1'b1);
      check("midreset_bus_a", 32'(io_input_bus), 32'h0);
      step(10'h2A5, 4'hF, 4'h0, 1'b1);
      check("midreset_bus_b", 32'(io_input_bus), 32'h0);
      clear_stats();
      repeat (5) step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("postreset_edge5", 32'(io_input_bus[9:0]), 32'h0);
      step(10'h2A5, 4'hF, 4'h0, 1'b0);
      check("postreset_edge6", 32'(io_input_bus[9:0]), 32'h2A5);
      check("postreset_pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'h0);

      // Randomized activity checked entirely through the scoreboard
      sw_r = 10'h2A5;
      k_r  = 4'hF;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 5) == 0) sw_r = 10'($urandom);
         if ($urandom_range(0, 4) == 0) k_r = 4'($urandom);
         clr_r = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'h0;
         rst_r = ($urandom_range(0, 149) == 0);
         step(sw_r, k_r, clr_r, rst_r);
      end

      // Every queued expectation must have been consumed
      repeat (3) @(posedge clock);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the cycles a synchronized input must hold a new level before the debounced output follows it (legal range 2..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 20, meaning the width of each per-bit debounce counter.
REQ-003 SHALL have parameter KEY_ACTIVE_LOW, default 1, meaning raw key pins read 0 when pressed.
REQ-004 SHALL have port clock  input  1  meaning the single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port switches_in  input  10  meaning raw, unsynchronized slide-switch pins.
REQ-007 SHALL have port keys_in  input  4  meaning raw, unsynchronized push-button pins.
REQ-008 SHALL have port clear_events  input  4  meaning per-key clear strobe for key_event.
REQ-009 SHALL have port io_input_bus  output  14  meaning {debounced keys[3:0], debounced switches[9:0]}, key bits 1 = pressed; feeds the data memory IO read path.
REQ-010 SHALL have port key_pressed  output  4  meaning a one-cycle pulse per debounced key press.
REQ-011 SHALL have port key_event  output  4  meaning a sticky per-key press flag.

Function
REQ-012 SHALL pass each of the 14 raw bits through a 2-flop synchronizer before any other use.
REQ-013 SHALL invert key bits after synchronization when KEY_ACTIVE_LOW=1, so the normalized level is 1 = pressed; switches SHALL never be inverted.
REQ-014 SHALL hold, per bit, a stable register and a CNT_W-bit counter, each bit independent of the others.
REQ-015 SHALL compare the normalized synchronized bit against the stable bit every cycle; when they are equal, the counter SHALL load 0.
REQ-016 SHALL increment the counter on a differing cycle while the counter < DEBOUNCE_CYCLES-1.
REQ-017 SHALL load the stable bit with the new level and clear the counter on a differing cycle with counter == DEBOUNCE_CYCLES-1.
REQ-018 SHALL, for a raw level change first sampled at edge 1 and held, update the stable bit at edge DEBOUNCE_CYCLES+2, visible on io_input_bus after that edge.
REQ-019 SHALL leave the stable bit unchanged for any glitch that reverts before DEBOUNCE_CYCLES consecutive differing cycles; the counter restarts from 0 on the next difference.
REQ-020 SHALL drive io_input_bus directly from the stable registers, with no combinational path from the raw pins.
REQ-021 SHALL assert key_pressed[i] for exactly one cycle: it is set on the edge where stable key bit i goes 0->1 and cleared on the next edge; key releases SHALL produce no pulse.
REQ-022 SHALL set key_event[i] on the same edge as key_pressed[i] and hold it until an edge with clear_events[i]=1.
REQ-023 SHALL let set win when a set and clear_events[i] occur on the same edge.
REQ-024 SHALL ignore clear_events[i] when key_event[i] is already 0.

Reset
REQ-025 SHALL, while reset=0, force switch synchronizer flops to 0 and key synchronizer flops to the released raw level (1 if KEY_ACTIVE_LOW, else 0).
REQ-026 SHALL, while reset=0, force all stable registers, counters, key_pressed and key_event to 0, so that io_input_bus=14'h0000, key_pressed=4'h0 and key_event=4'h0.
REQ-027 SHALL produce no key_pressed pulse after reset release while keys are held released.
REQ-028 SHALL abandon any partial debounce count when reset asserts mid-count; the count restarts from 0 after release.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset with keys_in=4'hF and switches_in=0, then release for 20 cycles -> io_input_bus=0, and key_pressed and key_event stay 0 throughout.
REQ-030 switches_in 0->10'h2A5 first sampled at edge 1, held -> io_input_bus[9:0] = 10'h2A5 after edge 6, and still 0 after edge 5.
REQ-031 keys_in[2] low for 3 cycles then high -> io_input_bus[12] stays 0 and there are no pulses; then low for 10 cycles -> io_input_bus[12]=1 after edge 6, key_pressed[2] high for exactly that one cycle, key_event[2]=1.
REQ-032 key_event[2]=1, then clear_events[2] pulsed for one cycle -> key_event[2]=0; a clear coincident with a new press edge -> key_event[2] remains 1.
REQ-033 Bounce pattern on keys_in[0] (L,H,L,H,L then held L) -> exactly one key_pressed[0] pulse, 4 cycles after the last transition plus 2 synchronizer cycles.
REQ-034 Reset asserted at counter=2 during a switch change, released with the level still held -> io_input_bus=0 during reset, and the bit updates 6 edges after release.
